// File: rtl/bias_upd.sv
// Bias update controller: counts mini-batch samples, then subtracts the
// shift-averaged accumulated delta from the held bias with saturation.
module bias_upd #(
  parameter int               WIDTH      = 32,
  parameter int               FRAC       = 24,
  parameter int               BATCH_LOG2 = 2,
  parameter logic [WIDTH-1:0] INIT_BIAS  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_smp,
  input  logic [WIDTH-1:0] i_acc,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_ld_val,
  output logic [WIDTH-1:0] o_bias,
  output logic             o_acc_clr,
  output logic             o_busy,
  output logic             o_upd_done,
  output logic             o_ovr
);

  if (BATCH_LOG2 < 1 || BATCH_LOG2 >= WIDTH || FRAC >= WIDTH) begin : g_bad_param
    $error("bias_upd: BATCH_LOG2 must be in [1, WIDTH-1] and FRAC below WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_CLR   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                  state_reg, state_next;
  logic [BATCH_LOG2-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]        bias_reg, bias_next;
  logic                    ovr_reg, ovr_next;

  logic signed [WIDTH-1:0] upd;
  logic        [WIDTH:0]   diff;
  logic        [WIDTH-1:0] sat;

  // Averaging over the batch is a plain arithmetic shift (rounds toward -inf).
  assign upd  = $signed(i_acc) >>> BATCH_LOG2;
  assign diff = {bias_reg[WIDTH-1], bias_reg} - {upd[WIDTH-1], upd};

  // One extra bit of headroom: overflow shows as the top two bits disagreeing.
  always_comb begin
    sat = diff[WIDTH-1:0];
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      sat = diff[WIDTH] ? MAX_NEG : MAX_POS;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bias_next  = bias_reg;
    ovr_next   = ovr_reg | (i_smp & (state_reg != S_IDLE));
    case (state_reg)
      S_IDLE: begin
        if (i_ld) begin
          bias_next = i_ld_val;
        end
        if (i_smp) begin
          cnt_next = cnt_reg + 1'b1;
          if (&cnt_reg) begin
            state_next = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        bias_next  = sat;
        state_next = S_CLR;
      end
      S_CLR: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      bias_reg  <= INIT_BIAS;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bias_reg  <= bias_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign o_bias     = bias_reg;
  assign o_busy     = (state_reg != S_IDLE);
  assign o_acc_clr  = (state_reg == S_CLR);
  assign o_upd_done = (state_reg == S_CLR);
  assign o_ovr      = ovr_reg;

endmodule

// File: doc/bias_upd.md
# bias_upd

Bias update controller for one neuron's bias term. It sits downstream of the per-neuron bias accumulator and counts the training samples fed into that accumulator. At the end of each mini-batch it reads the accumulated learning-rate-scaled delta, averages it by an arithmetic shift, subtracts it from the stored bias with saturation, and pulses a clear back to the accumulator. The held bias feeds the forward-path neuron adder.

## Interface
Parameters:
- WIDTH, 32, datapath width; all values signed fixed point
- FRAC, 24, fractional bits (1.0 = 0x01000000 at defaults)
- BATCH_LOG2, 2, log2 of mini-batch size (batch = 4 at default)
- INIT_BIAS, 32'h0, bias value after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_smp  in  1  one sample accepted by the accumulator this cycle; same pulse as accumulator enable
- i_acc  in  WIDTH  accumulator output (sum of lr*delta), signed
- i_ld  in  1  load external bias value
- i_ld_val  in  WIDTH  value for i_ld
- o_bias  out  WIDTH  current bias, registered
- o_acc_clr  out  1  one-cycle pulse; accumulator clears on the next edge
- o_busy  out  1  high in APPLY and CLR states
- o_upd_done  out  1  one-cycle pulse, coincident with o_acc_clr
- o_ovr  out  1  sticky flag: i_smp arrived while o_busy

## Operation
- Reset (rst=0, asynchronous): state IDLE, sample count 0, o_bias=INIT_BIAS, o_acc_clr=0, o_busy=0, o_upd_done=0, o_ovr=0.
- States: IDLE, APPLY, CLR.
- IDLE:
  - i_smp increments the BATCH_LOG2-bit sample count.
  - When i_smp arrives with count = 2^BATCH_LOG2-1, count wraps to 0 and the next state is APPLY.
  - i_ld loads o_bias <= i_ld_val. The count is unaffected.
  - i_ld and i_smp in the same cycle: both take effect.
- APPLY (one cycle): i_acc already includes the last sample, because the accumulator registered it on the same edge that entered APPLY.
  - Compute the update as i_acc >>> BATCH_LOG2 (arithmetic shift).
  - Form diff = o_bias - update in WIDTH+1 bits.
  - Clamp diff to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and register it into o_bias.
  - Next state is CLR.
- CLR (one cycle): o_acc_clr=1 and o_upd_done=1. Next state is IDLE.
- i_smp while o_busy:
  - The sample is not counted and o_ovr is set.
  - o_ovr clears only on reset.
  - Upstream must hold samples while o_busy is high.
- i_ld while o_busy is ignored.
- Outputs o_acc_clr and o_upd_done are Moore outputs decoded from state. o_busy = (state != IDLE).

## Timing
- Cycle N: i_smp=1 with count=batch-1. Edge N: state becomes APPLY.
- Cycle N+1: o_busy=1. Edge N+1: o_bias takes the new value.
- Cycle N+2: o_acc_clr=1, o_upd_done=1, o_busy=1. Edge N+2: state becomes IDLE.
- Cycle N+3: o_busy=0 and a new sample may be accepted.
- Update latency is 1 cycle from the last sample's edge to the o_bias change. The block occupies 3 cycles before it accepts again.
- Reset asserted mid-APPLY or mid-CLR returns every output to its reset value immediately. A partial update is never committed after reset.

## Test plan
Defaults throughout: WIDTH=32, FRAC=24, BATCH_LOG2=2.

1. **Reset:** assert rst=0 mid-run, then release → o_bias=0x00000000, o_busy=0, o_acc_clr=0, o_ovr=0, count restarts from 0.
2. **Basic update:** i_ld with i_ld_val=0x01000000, then 4 i_smp pulses, with i_acc=0x00400000 during APPLY → o_bias=0x00F00000 one cycle after the 4th-sample edge. o_acc_clr and o_upd_done are high for exactly one cycle, two cycles after that edge.
3. **Negative gradient:** o_bias=0x00000000, i_acc=0xFFC00000 at APPLY → update 0xFFF00000, o_bias=0x00100000.
4. **Saturation:** o_bias=0x7FFFFFF0, i_acc=0x80000000 → update 0xE0000000, o_bias=0x7FFFFFFF. Then o_bias=0x80000010, i_acc=0x7FFFFFFC → o_bias=0x80000000.
5. **Overrun:** pulse i_smp during APPLY and during CLR → o_ovr=1 and stays 1. The following batch still needs 4 IDLE samples before the next APPLY. An i_ld during CLR leaves o_bias unchanged.
6. **Simultaneous load and sample:** in IDLE at count=3, assert i_ld (i_ld_val=0x02000000) and i_smp together with i_acc=0 → APPLY yields o_bias=0x02000000, and the CLR pulse occurs.
